// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// cpu_ctrl_pkg : opcode, state and datapath-select encodings for the RV32I sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_IMM  = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MDR = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Combinational strobe/select bundle driven by the sequencer decode.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       illegal_instr;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// mem_wait_timer : counts memory wait cycles, flags the last allowed wait cycle
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timer
      localparam int W = $clog2(MEM_TIMEOUT + 1);
      localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

      logic [W-1:0] count;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + W'(1);
        end
      end

      // Expires on the MEM_TIMEOUT-th consecutive waiting cycle.
      assign expired = enable && (count == LIMIT);
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit : FETCH/DECODE/EXEC/MEM/WB sequencer for multi-cycle RV32I
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_cond,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       illegal_instr,
  output logic       mem_error,
  output logic       is_halted
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  ctrl_t  ctrl_gated;
  logic   waiting;
  logic   timeout;
  logic   mem_error_flag;

  assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_FETCH;
      mem_error_flag <= 1'b0;
    end else begin
      state <= next_state;
      if (timeout) begin
        mem_error_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl       = '0;
    next_state = state;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          next_state    = ST_DECODE;
        end else if (timeout) begin
          next_state = ST_HALT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: begin
            next_state = ST_EXEC;
          end
          OP_SYSTEM: begin
            if (halt_cond) begin
              next_state = ST_HALT;
            end else begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_SRC_PC4;
              next_state     = ST_FETCH;
            end
          end
          default: begin
            ctrl.illegal_instr = 1'b1;
            ctrl.pc_write      = 1'b1;
            ctrl.pc_source     = PC_SRC_PC4;
            next_state         = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        case (opcode)
          OP_R: begin
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = ALU_OP_FUNCT;
            next_state     = ST_WB;
          end
          OP_I: begin
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_FUNCT;
            next_state     = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
            next_state     = ST_MEM;
          end
          OP_BRANCH: begin
            // Taken loads PC+imm via pc_write_cond; not-taken loads PC+4 via pc_write.
            ctrl.alu_src_b     = SRC_B_RS2;
            ctrl.alu_op        = ALU_OP_BRANCH;
            ctrl.pc_write_cond = 1'b1;
            if (bcond) begin
              ctrl.pc_source = PC_SRC_IMM;
            end else begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_SRC_PC4;
            end
            next_state = ST_FETCH;
          end
          OP_JAL, OP_JALR: begin
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
            next_state     = ST_WB;
          end
          default: begin
            next_state = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        ctrl.iord = 1'b1;
        if (opcode == OP_STORE) begin
          ctrl.mem_write = 1'b1;
        end else begin
          ctrl.mem_read = 1'b1;
        end
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_PC4;
            next_state     = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end else if (timeout) begin
          next_state = ST_HALT;
        end
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        case (opcode)
          OP_LOAD: begin
            ctrl.wb_sel    = WB_SEL_MDR;
            ctrl.pc_source = PC_SRC_PC4;
          end
          OP_JAL: begin
            ctrl.wb_sel    = WB_SEL_PC4;
            ctrl.pc_source = PC_SRC_IMM;
          end
          OP_JALR: begin
            ctrl.wb_sel    = WB_SEL_PC4;
            ctrl.pc_source = PC_SRC_JALR;
          end
          default: begin
            ctrl.wb_sel    = WB_SEL_ALU;
            ctrl.pc_source = PC_SRC_PC4;
          end
        endcase
        next_state = ST_FETCH;
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_FETCH;
      end
    endcase
  end

  // Reset forces every output low immediately, so an aborted access never strobes.
  assign ctrl_gated    = reset_n ? ctrl : '0;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign iord          = ctrl_gated.iord;
  assign ir_write      = ctrl_gated.ir_write;
  assign reg_write     = ctrl_gated.reg_write;
  assign wb_sel        = ctrl_gated.wb_sel;
  assign alu_src_a     = ctrl_gated.alu_src_a;
  assign alu_src_b     = ctrl_gated.alu_src_b;
  assign alu_op        = ctrl_gated.alu_op;
  assign pc_write      = ctrl_gated.pc_write;
  assign pc_write_cond = ctrl_gated.pc_write_cond;
  assign pc_source     = ctrl_gated.pc_source;
  assign illegal_instr = ctrl_gated.illegal_instr;
  assign mem_error     = reset_n && mem_error_flag;
  assign is_halted     = reset_n && (state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// tb_multicycle_control_unit : directed per-cycle scoreboard for the sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  // Output vector layout:
  // {mem_read, mem_write, iord, ir_write, reg_write, wb_sel[1:0], alu_src_a,
  //  alu_src_b[1:0], alu_op[1:0], pc_write, pc_write_cond, pc_source[1:0],
  //  illegal_instr, mem_error, is_halted}
  localparam logic [18:0] MR       = 19'h40000;
  localparam logic [18:0] MW       = 19'h20000;
  localparam logic [18:0] IORD     = 19'h10000;
  localparam logic [18:0] IRW      = 19'h08000;
  localparam logic [18:0] RW       = 19'h04000;
  localparam logic [18:0] WB_MDR   = 19'h01000;
  localparam logic [18:0] WB_PC4   = 19'h02000;
  localparam logic [18:0] A_RS1    = 19'h00800;
  localparam logic [18:0] B_IMM    = 19'h00200;
  localparam logic [18:0] OP_BR    = 19'h00080;
  localparam logic [18:0] OP_FN    = 19'h00100;
  localparam logic [18:0] PCW      = 19'h00040;
  localparam logic [18:0] PCWC     = 19'h00020;
  localparam logic [18:0] PCS_IMM  = 19'h00008;
  localparam logic [18:0] PCS_JALR = 19'h00010;
  localparam logic [18:0] ILL      = 19'h00004;
  localparam logic [18:0] MERR     = 19'h00002;
  localparam logic [18:0] HLT      = 19'h00001;
  localparam logic [18:0] NONE     = 19'h00000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'h00;
  logic       bcond = 1'b0;
  logic       halt_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, alu_op, pc_source;
  logic       alu_src_a, pc_write, pc_write_cond, illegal_instr, mem_error, is_halted;

  int total = 0;
  int bad = 0;
  logic [18:0] exp_q[$];
  string       name_q[$];

  multicycle_control_unit #(
    .MEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .bcond         (bcond),
    .halt_cond     (halt_cond),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .iord          (iord),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .illegal_instr (illegal_instr),
    .mem_error     (mem_error),
    .is_halted     (is_halted)
  );

  always #5 clk = ~clk;

  // Monitor: each cycle that has a queued expectation, compare mid-cycle.
  always @(negedge clk) begin
    logic [18:0] act;
    logic [18:0] exp_v;
    string       nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act   = {mem_read, mem_write, iord, ir_write, reg_write, wb_sel, alu_src_a,
               alu_src_b, alu_op, pc_write, pc_write_cond, pc_source,
               illegal_instr, mem_error, is_halted};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL %s: got %05h expected %05h", nm, act, exp_v);
      end
    end
  end

  task automatic step(input logic [6:0] op, input logic rdy, input logic bc,
                      input logic hc, input logic [18:0] e, input string nm);
    opcode    = op;
    mem_ready = rdy;
    bcond     = bc;
    halt_cond = hc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    step(7'h33, 1, 0, 0, NONE, "reset_a");
    step(7'h33, 1, 0, 0, NONE, "reset_b");
    reset_n = 1'b1;

    // add x3,x1,x2
    step(7'h33, 1, 0, 0, MR | IRW,        "add_fetch");
    step(7'h33, 0, 0, 0, NONE,            "add_decode");
    step(7'h33, 0, 0, 0, A_RS1 | OP_FN,   "add_exec");
    step(7'h33, 0, 0, 0, RW | PCW,        "add_wb");
    // addi
    step(7'h13, 1, 0, 0, MR | IRW,              "addi_fetch");
    step(7'h13, 0, 0, 0, NONE,                  "addi_decode");
    step(7'h13, 0, 0, 0, A_RS1 | B_IMM | OP_FN, "addi_exec");
    step(7'h13, 0, 0, 0, RW | PCW,              "addi_wb");
    // lw, ready arrives on the last allowed wait cycle
    step(7'h03, 1, 0, 0, MR | IRW,           "lw_fetch");
    step(7'h03, 0, 0, 0, NONE,               "lw_decode");
    step(7'h03, 0, 0, 0, A_RS1 | B_IMM,      "lw_exec");
    step(7'h03, 0, 0, 0, MR | IORD,          "lw_mem_wait1");
    step(7'h03, 0, 0, 0, MR | IORD,          "lw_mem_wait2");
    step(7'h03, 0, 0, 0, MR | IORD,          "lw_mem_wait3");
    step(7'h03, 1, 0, 0, MR | IORD,          "lw_mem_ready");
    step(7'h03, 0, 0, 0, RW | WB_MDR | PCW,  "lw_wb");
    // sw
    step(7'h23, 1, 0, 0, MR | IRW,         "sw_fetch");
    step(7'h23, 0, 0, 0, NONE,             "sw_decode");
    step(7'h23, 0, 0, 0, A_RS1 | B_IMM,    "sw_exec");
    step(7'h23, 1, 0, 0, MW | IORD | PCW,  "sw_mem");
    // beq taken
    step(7'h63, 1, 0, 0, MR | IRW,                          "beq_t_fetch");
    step(7'h63, 0, 0, 0, NONE,                              "beq_t_decode");
    step(7'h63, 0, 1, 0, A_RS1 | OP_BR | PCWC | PCS_IMM,    "beq_t_exec");
    // beq not taken
    step(7'h63, 1, 0, 0, MR | IRW,                     "beq_n_fetch");
    step(7'h63, 0, 0, 0, NONE,                         "beq_n_decode");
    step(7'h63, 0, 0, 0, A_RS1 | OP_BR | PCWC | PCW,   "beq_n_exec");
    // jal
    step(7'h6F, 1, 0, 0, MR | IRW,                       "jal_fetch");
    step(7'h6F, 0, 0, 0, NONE,                           "jal_decode");
    step(7'h6F, 0, 0, 0, A_RS1 | B_IMM,                  "jal_exec");
    step(7'h6F, 0, 0, 0, RW | WB_PC4 | PCW | PCS_IMM,    "jal_wb");
    // jalr
    step(7'h67, 1, 0, 0, MR | IRW,                       "jalr_fetch");
    step(7'h67, 0, 0, 0, NONE,                           "jalr_decode");
    step(7'h67, 0, 0, 0, A_RS1 | B_IMM,                  "jalr_exec");
    step(7'h67, 0, 0, 0, RW | WB_PC4 | PCW | PCS_JALR,   "jalr_wb");
    // illegal opcode
    step(7'h7F, 1, 0, 0, MR | IRW,   "ill_fetch");
    step(7'h7F, 0, 0, 0, ILL | PCW,  "ill_decode");
    // ecall without halt
    step(7'h73, 1, 0, 0, MR | IRW,   "ecall_fetch");
    step(7'h73, 0, 0, 0, PCW,        "ecall_decode");
    // ecall with halt
    step(7'h73, 1, 0, 1, MR | IRW,   "ecall_h_fetch");
    step(7'h73, 0, 0, 1, NONE,       "ecall_h_decode");
    step(7'h73, 1, 0, 0, HLT,        "halt_1");
    step(7'h73, 0, 0, 0, HLT,        "halt_2");
    step(7'h73, 1, 0, 0, HLT,        "halt_3");
    reset_n = 1'b0;
    step(7'h33, 1, 0, 0, NONE,       "rst_from_halt");
    reset_n = 1'b1;
    // fetch timeout with MEM_TIMEOUT=4
    step(7'h33, 0, 0, 0, MR,          "to_wait1");
    step(7'h33, 0, 0, 0, MR,          "to_wait2");
    step(7'h33, 0, 0, 0, MR,          "to_wait3");
    step(7'h33, 0, 0, 0, MR,          "to_wait4");
    step(7'h33, 0, 0, 0, HLT | MERR,  "to_halt_a");
    step(7'h33, 1, 0, 0, HLT | MERR,  "to_halt_b");
    reset_n = 1'b0;
    step(7'h33, 1, 0, 0, NONE,        "rst_after_timeout");
    reset_n = 1'b1;
    step(7'h03, 0, 0, 0, MR,              "fetch_err_cleared");
    step(7'h03, 1, 0, 0, MR | IRW,        "lw2_fetch");
    step(7'h03, 0, 0, 0, NONE,            "lw2_decode");
    step(7'h03, 0, 0, 0, A_RS1 | B_IMM,   "lw2_exec");
    step(7'h03, 0, 0, 0, MR | IORD,       "lw2_mem_wait");
    // async reset mid-MEM
    reset_n = 1'b0;
    step(7'h03, 0, 0, 0, NONE,            "rst_mid_mem");
    reset_n = 1'b1;
    step(7'h03, 0, 0, 0, MR,              "fetch_after_mid_rst");

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
